// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared types and constants for the ID/EX pipeline register.
package id_ex_stage_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
        ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_LHB = 4'd8, ALU_LLB = 4'd9
    } aluop_e;

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    localparam logic [1:0] DRAIN_CYCLES = 2'd3;

    typedef struct packed {
        logic en_z;
        logic en_n;
        logic en_v;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
        logic hlt;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // R0 is hardwired, so a write to it can never be a forwarding source
    function automatic logic fwd_hit(input logic wr, input logic [3:0] rd, input logic [3:0] src);
        return wr && (rd != 4'd0) && (rd == src);
    endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side inputs and execute-side outputs of the ID/EX register.
// Forwarding signals exist only when ID_EX_FWD_EN is defined.
interface id_ex_stage_if;
    logic        stall, flush;
    logic [15:0] id_alu_in1, id_alu_in2, id_sw_data;
    logic [3:0]  id_rs, id_rt, id_rd, id_aluop;
    logic        id_en_z, id_en_n, id_en_v, id_memread, id_memwrite, id_memtoreg, id_regwrite, id_hlt;
    logic [15:0] ex_alu_in1, ex_alu_in2, ex_sw_data;
    logic [3:0]  ex_rs, ex_rt, ex_rd, ex_aluop;
    logic        ex_en_z, ex_en_n, ex_en_v, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_hlt;
    logic        halted;
`ifdef ID_EX_FWD_EN
    logic        id_fwd_ok1, id_fwd_ok2;
    logic        exmem_regwrite, memwb_regwrite;
    logic [3:0]  exmem_rd, memwb_rd;
    logic [15:0] exmem_result, memwb_result;
`endif

    modport master (
        output stall, flush, id_alu_in1, id_alu_in2, id_sw_data, id_rs, id_rt, id_rd, id_aluop,
               id_en_z, id_en_n, id_en_v, id_memread, id_memwrite, id_memtoreg, id_regwrite, id_hlt,
        input  ex_alu_in1, ex_alu_in2, ex_sw_data, ex_rs, ex_rt, ex_rd, ex_aluop,
               ex_en_z, ex_en_n, ex_en_v, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_hlt, halted
`ifdef ID_EX_FWD_EN
        , output id_fwd_ok1, id_fwd_ok2, exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
                 exmem_result, memwb_result
`endif
    );

    modport slave (
        input  stall, flush, id_alu_in1, id_alu_in2, id_sw_data, id_rs, id_rt, id_rd, id_aluop,
               id_en_z, id_en_n, id_en_v, id_memread, id_memwrite, id_memtoreg, id_regwrite, id_hlt,
        output ex_alu_in1, ex_alu_in2, ex_sw_data, ex_rs, ex_rt, ex_rd, ex_aluop,
               ex_en_z, ex_en_n, ex_en_v, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_hlt, halted
`ifdef ID_EX_FWD_EN
        , input id_fwd_ok1, id_fwd_ok2, exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
                exmem_result, memwb_result
`endif
    );
endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// id_ex_fwd_sel: picks one operand from EX/MEM, MEM/WB or decode, youngest producer first.
module id_ex_fwd_sel
    import id_ex_stage_pkg::*;
(
    input  logic        ok,
    input  logic [3:0]  src,
    input  logic [15:0] val,
    input  logic        exmem_regwrite,
    input  logic [3:0]  exmem_rd,
    input  logic [15:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [3:0]  memwb_rd,
    input  logic [15:0] memwb_result,
    output logic [15:0] out
);
    assign out = (ok && fwd_hit(exmem_regwrite, exmem_rd, src)) ? exmem_result :
                 (ok && fwd_hit(memwb_regwrite, memwb_rd, src)) ? memwb_result : val;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with bubble insertion and HLT drain/halt FSM.
// Define ID_EX_FWD_EN to add operand forwarding from EX/MEM and MEM/WB.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    logic [15:0] in1, in2, sw;
    logic [1:0]  state, cnt;
    ctrl_t       id_ctrl, ex_ctrl;
    logic        take;

`ifdef ID_EX_FWD_EN
    id_ex_fwd_sel u_fwd1 (
        .ok(bus.id_fwd_ok1), .src(bus.id_rs), .val(bus.id_alu_in1),
        .exmem_regwrite(bus.exmem_regwrite), .exmem_rd(bus.exmem_rd), .exmem_result(bus.exmem_result),
        .memwb_regwrite(bus.memwb_regwrite), .memwb_rd(bus.memwb_rd), .memwb_result(bus.memwb_result),
        .out(in1)
    );
    id_ex_fwd_sel u_fwd2 (
        .ok(bus.id_fwd_ok2), .src(bus.id_rt), .val(bus.id_alu_in2),
        .exmem_regwrite(bus.exmem_regwrite), .exmem_rd(bus.exmem_rd), .exmem_result(bus.exmem_result),
        .memwb_regwrite(bus.memwb_regwrite), .memwb_rd(bus.memwb_rd), .memwb_result(bus.memwb_result),
        .out(in2)
    );
    // store data is always register-sourced, hence the constant enable
    id_ex_fwd_sel u_fwd_sw (
        .ok(1'b1), .src(bus.id_rt), .val(bus.id_sw_data),
        .exmem_regwrite(bus.exmem_regwrite), .exmem_rd(bus.exmem_rd), .exmem_result(bus.exmem_result),
        .memwb_regwrite(bus.memwb_regwrite), .memwb_rd(bus.memwb_rd), .memwb_result(bus.memwb_result),
        .out(sw)
    );
`else
    assign in1 = bus.id_alu_in1;
    assign in2 = bus.id_alu_in2;
    assign sw  = bus.id_sw_data;
`endif

    assign take    = (state == RUN) && !bus.stall && !bus.flush;
    assign id_ctrl = '{en_z: bus.id_en_z, en_n: bus.id_en_n, en_v: bus.id_en_v,
                       memread: bus.id_memread, memwrite: bus.id_memwrite, memtoreg: bus.id_memtoreg,
                       regwrite: bus.id_regwrite && (bus.id_rd != 4'd0), hlt: bus.id_hlt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            cnt            <= 2'd0;
            ex_ctrl        <= CTRL_BUBBLE;
            bus.ex_alu_in1 <= '0;
            bus.ex_alu_in2 <= '0;
            bus.ex_sw_data <= '0;
            bus.ex_rs      <= '0;
            bus.ex_rt      <= '0;
            bus.ex_rd      <= '0;
            bus.ex_aluop   <= '0;
        end else begin
            ex_ctrl        <= take ? id_ctrl : CTRL_BUBBLE;
            bus.ex_alu_in1 <= take ? in1 : '0;
            bus.ex_alu_in2 <= take ? in2 : '0;
            bus.ex_sw_data <= take ? sw : '0;
            bus.ex_rs      <= take ? bus.id_rs : '0;
            bus.ex_rt      <= take ? bus.id_rt : '0;
            bus.ex_rd      <= take ? bus.id_rd : '0;
            bus.ex_aluop   <= take ? bus.id_aluop : '0;
            if (take && bus.id_hlt) begin
                state <= DRAIN;
                cnt   <= 2'd0;
            end else if (state == DRAIN) begin
                if (cnt == DRAIN_CYCLES) state <= HALTED;
                else cnt <= cnt + 2'd1;
            end
        end
    end

    assign bus.ex_en_z     = ex_ctrl.en_z;
    assign bus.ex_en_n     = ex_ctrl.en_n;
    assign bus.ex_en_v     = ex_ctrl.en_v;
    assign bus.ex_memread  = ex_ctrl.memread;
    assign bus.ex_memwrite = ex_ctrl.memwrite;
    assign bus.ex_memtoreg = ex_ctrl.memtoreg;
    assign bus.ex_regwrite = ex_ctrl.regwrite;
    assign bus.ex_hlt      = ex_ctrl.hlt;
    assign bus.halted      = (state == HALTED);
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock; one clock only.
REQ-002 SHALL have: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: stall  input  1  load-use stall from decode; insert bubble.
REQ-004 SHALL have: flush  input  1  squash from branch resolution; insert bubble.
REQ-005 SHALL have: id_alu_in1, id_alu_in2, id_sw_data  input  16 each  decode data bundle.
REQ-006 SHALL have: id_rs, id_rt, id_rd, id_aluop  input  4 each  register specifiers, ALU op.
REQ-007 SHALL have: id_en_z, id_en_n, id_en_v, id_memread, id_memwrite, id_memtoreg, id_regwrite, id_hlt  input  1 each  decode control.
REQ-008 SHALL have: ex_* outputs, one per id_* input, same width, registered.
REQ-009 SHALL have: halted  output  1  pipeline drained after HLT.
REQ-010 SHALL have, only with ID_EX_FWD_EN: id_fwd_ok1, id_fwd_ok2  input  1  operand is register-sourced; exmem_regwrite, memwb_regwrite  input  1; exmem_rd, memwb_rd  input  4; exmem_result, memwb_result  input  16.

Function
REQ-011 SHALL capture the id_* bundle into ex_* on each rising clk when not bubbling and FSM is RUN.
REQ-012 SHALL have latency exactly one cycle, id_* to ex_*.
REQ-013 SHALL load a bubble when stall=1, flush=1, or both: all ex_* outputs 0.
REQ-014 SHALL treat simultaneous stall and flush as one bubble; no extra cycle.
REQ-015 SHALL force ex_regwrite to 0 when id_rd=0 (R0 never written).
REQ-016 SHALL implement FSM states RUN, DRAIN, HALTED.
REQ-017 RUN->DRAIN when an instruction with id_hlt=1 is captured (not bubbled); the HLT itself passes to ex_hlt.
REQ-018 DRAIN SHALL load bubbles and count 3 cycles with a 2-bit counter; after the 3rd, go to HALTED.
REQ-019 HALTED SHALL load bubbles indefinitely and assert halted=1; only reset exits.
REQ-020 id_hlt arriving with stall or flush SHALL be discarded; FSM stays RUN.
REQ-021 flush during DRAIN or HALTED SHALL not alter state or counter.

Reset
REQ-022 rst_n=0 SHALL immediately clear all ex_* to 0, halted to 0, FSM to RUN, counter to 0, regardless of clk.
REQ-023 Reset mid-DRAIN SHALL abort the drain; first captured instruction after release is the id_* bundle present at the first edge.

Configuration
REQ-024 Macro ID_EX_FWD_EN SHALL compile in operand forwarding and its REQ-010 ports.
REQ-025 With it: an operand with id_fwd_okN=1 SHALL take exmem_result if exmem_regwrite=1, exmem_rd!=0 and exmem_rd equals its source register (id_rs for operand 1, id_rt for operand 2); else memwb_result under the same rule with memwb_*; else id_alu_inN.
REQ-026 With it: EX/MEM SHALL win over MEM/WB when both match; id_sw_data forwards using id_rt with the same priority, ignoring id_fwd_ok2.
REQ-027 Without it: id_alu_in1/2 and id_sw_data SHALL pass unmodified; REQ-010 ports absent.

Structure
REQ-028 Shared package SHALL hold: FSM state enum, ALUOp encodings, DRAIN_CYCLES=3, bubble constant for the control bundle.
REQ-029 Forwarding mux SHALL be sub-module id_ex_fwd_sel, instantiated only under ID_EX_FWD_EN.

Verification
REQ-030 id_alu_in1=0x1234, id_regwrite=1, id_rd=3, no stall -> next edge ex_alu_in1=0x1234, ex_regwrite=1, ex_rd=3.
REQ-031 stall=1 and flush=1 same cycle with id_memwrite=1 -> next edge all ex_* = 0; following cycle normal capture resumes.
REQ-032 id_hlt=1 captured -> ex_hlt=1 one cycle, then 3 bubble cycles, halted=1 on the 4th edge after capture and held.
REQ-033 rst_n low 2 cycles into DRAIN -> halted=0, ex_*=0 immediately; new instruction captured after release.
REQ-034 ID_EX_FWD_EN: id_rs=5, id_fwd_ok1=1, exmem_rd=5/0xAAAA, memwb_rd=5/0xBBBB, both regwrite=1 -> ex_alu_in1=0xAAAA; exmem_rd=0 -> 0xBBBB.
REQ-035 id_rd=0, id_regwrite=1 -> ex_regwrite=0.
